// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_reader
//  Description : Read-side dump engine for a register file. When it accepts a
//                start pulse, it walks an inclusive address range through one
//                combinational regfile read port. Each register is streamed
//                out as a valid/ready beat carrying {addr, data, last}.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock; all state updates on the rising edge
//    rst        in   asynchronous active-high reset
//    start      in   1-cycle dump request; ignored while busy or with abort
//    abort      in   cancel any dump in progress; wins over start
//    lo_addr    in   first address, sampled on an accepted start
//    hi_addr    in   last address, sampled on an accepted start
//    rd_addr    out  registered address to the regfile read port
//    rd_data    in   regfile read data for rd_addr, same cycle
//    out_valid  out  beat available
//    out_ready  in   sink accepts the beat when out_valid & out_ready
//    out_addr   out  register index of the beat
//    out_data   out  register contents of the beat
//    out_last   out  beat is the final address of the range
//    busy       out  dump in progress (RUN or DRAIN)
//    done       out  1-cycle pulse after the last beat handshake
// ============================================================================
module regfile_dump_reader #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lo_addr,
    input  logic [W-1:0] hi_addr,
    output logic [W-1:0] rd_addr,
    input  logic [B-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_addr,
    output logic [B-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [W-1:0]   rd_addr_q,   rd_addr_d;
    logic [W-1:0]   end_addr_q,  end_addr_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_addr_q,  out_addr_d;
    logic [B-1:0]   out_data_q,  out_data_d;
    logic           out_last_q,  out_last_d;
    logic           done_q,      done_d;

    // The one-entry beat slot can accept a new capture when it is empty, or
    // when the sink consumes the current beat on this same edge.
    logic slot_free;
    logic at_end;

    assign slot_free = !out_valid_q || out_ready;
    assign at_end    = (rd_addr_q == end_addr_q);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        end_addr_d  = end_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (abort) begin
            // Any pending beat is dropped, and no done pulse is produced.
            state_d     = S_IDLE;
            rd_addr_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_RUN;
                        rd_addr_d  = lo_addr;
                        end_addr_d = hi_addr;
                    end
                end
                S_RUN: begin
                    if (slot_free) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = rd_addr_q;
                        out_data_d  = rd_data;
                        out_last_d  = at_end;
                        if (at_end) begin
                            state_d = S_DRAIN;
                        end else begin
                            // Wraps modulo 2**W so that hi < lo ranges pass through 0.
                            rd_addr_d = rd_addr_q + W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            end_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            end_addr_q  <= end_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    // done is asserted only in the cycle after the machine has returned to IDLE,
    // so it can never overlap busy.
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump_reader
//  Description : Self-checking bench for regfile_dump_reader. Contains a
//                behavioural register array and an expected-beat list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int B     = 32;
    localparam int W     = 5;
    localparam int DEPTH = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] lo_addr;
    logic [W-1:0] hi_addr;
    logic [W-1:0] rd_addr;
    logic [B-1:0] rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_addr;
    logic [B-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    logic [B-1:0] regs [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    assign rd_data = regs[rd_addr];

    regfile_dump_reader #(.B(B), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .lo_addr   (lo_addr),
        .hi_addr   (hi_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The dump is started at a negedge, and the DUT is observed at every later negedge.
    // The cycle right after the sampling posedge is cycle 1.
    task automatic run_dump(input string name, input int lo, input int hi,
                            input bit rand_ready, input int restart_at);
        int exp_q[$];
        int n;
        int idx;
        int cyc;
        int last_hs;
        bit ready;
        bit prev_stall;
        logic [W-1:0] p_addr;
        logic [B-1:0] p_data;
        logic         p_last;
        n = (hi - lo + DEPTH) % DEPTH + 1;
        for (int k = 0; k < n; k++) exp_q.push_back((lo + k) % DEPTH);
        idx = 0;
        last_hs = 1000000;
        prev_stall = 1'b0;
        p_addr = '0; p_data = '0; p_last = 1'b0;

        start = 1'b1; lo_addr = W'(lo); hi_addr = W'(hi);
        @(negedge clk);
        start = 1'b0; lo_addr = W'($urandom); hi_addr = W'($urandom);
        cyc = 1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle1: busy=%b valid=%b expected busy=1 valid=0", name, busy, out_valid);
        end

        while (cyc < 800 && !(exp_q.size() == 0 && cyc > last_hs + 1)) begin
            checks++;
            if (done !== ((exp_q.size() == 0) && (cyc == last_hs + 1))) begin
                errors++;
                $display("FAIL %s done@%0d: got %b expected %b", name, cyc, done,
                         (exp_q.size() == 0) && (cyc == last_hs + 1));
            end
            if (done === 1'b1) begin
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_at_done: busy=%b valid=%b expected 0 0", name, busy, out_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== p_addr || out_data !== p_data || out_last !== p_last) begin
                    errors++;
                    $display("FAIL %s stall_hold@%0d: v=%b a=%0d d=%h l=%b expected v=1 a=%0d d=%h l=%b",
                             name, cyc, out_valid, out_addr, out_data, out_last, p_addr, p_data, p_last);
                end
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                lo_addr = W'($urandom); hi_addr = W'($urandom);
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = ready;
            if (out_valid === 1'b1 && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat: got addr %0d expected no beat", name, out_addr);
                end else begin
                    if (out_addr !== W'(exp_q[0]) || out_data !== regs[exp_q[0]] ||
                        out_last !== (exp_q.size() == 1)) begin
                        errors++;
                        $display("FAIL %s beat%0d: a=%0d d=%h l=%b expected a=%0d d=%h l=%b",
                                 name, idx, out_addr, out_data, out_last, exp_q[0],
                                 regs[exp_q[0]], exp_q.size() == 1);
                    end
                    if (!rand_ready) begin
                        checks++;
                        if (cyc != 2 + idx) begin
                            errors++;
                            $display("FAIL %s beat_cycle%0d: got %0d expected %0d", name, idx, cyc, 2 + idx);
                        end
                    end
                    void'(exp_q.pop_front());
                    idx++;
                    if (exp_q.size() == 0) last_hs = cyc;
                end
            end
            prev_stall = (out_valid === 1'b1) && !ready;
            p_addr = out_addr; p_data = out_data; p_last = out_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || idx != n) begin
            errors++;
            $display("FAIL %s beat_count: got %0d expected %0d (timeout)", name, idx, n);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        lo_addr = '0; hi_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_addr, out_valid, out_addr, out_data, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset: rd_addr=%0d v=%b a=%0d d=%h l=%b busy=%b done=%b expected all 0",
                     rd_addr, out_valid, out_addr, out_data, out_last, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < DEPTH; i++) regs[i] = B'(i * 32'h11111111);
        run_dump("full", 0, 31, 1'b0, -1);
    endtask

    task automatic test_single();
        for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
        run_dump("single", 5, 5, 1'b0, -1);
    endtask

    task automatic test_wrap();
        run_dump("wrap", 30, 1, 1'b0, -1);
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
        run_dump("rand_ready", 0, 31, 1'b1, -1);
        run_dump("rand_range", $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, -1);
    endtask

    task automatic test_abort();
        int guard;
        start = 1'b1; lo_addr = 5'd0; hi_addr = 5'd31; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(out_valid === 1'b1 && out_addr === 5'd9) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL abort: v=%b busy=%b done=%b rd_addr=%0d l=%b expected 0 0 0 0 0",
                     out_valid, busy, done, rd_addr, out_last);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b busy=%b expected 0 0", done, busy);
            end
        end
        run_dump("after_abort", 0, 31, 1'b0, -1);
    endtask

    task automatic test_ignored_and_reset();
        run_dump("restart_ignored", 2, 7, 1'b0, 4);
        start = 1'b1; abort = 1'b1; lo_addr = 5'd3; hi_addr = 5'd9;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL start_with_abort: busy=%b v=%b expected 0 0", busy, out_valid);
            end
            @(negedge clk);
        end
        start = 1'b1; lo_addr = 5'd0; hi_addr = 5'd31; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_addr, out_valid, out_addr, out_data, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_rst: rd_addr=%0d v=%b a=%0d d=%h l=%b busy=%b done=%b expected all 0",
                     rd_addr, out_valid, out_addr, out_data, out_last, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL after_rst: busy=%b done=%b expected 0 0", busy, done);
            end
        end
        run_dump("after_rst", 28, 3, 1'b0, -1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) regs[i] = '0;
        test_reset();
        test_full_dump();
        test_single();
        test_wrap();
        test_random_ready();
        test_abort();
        test_ignored_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
